msg_scan_driver: RTL and testbench
==================================

MSG_SCAN_DRIVER -- requirements
Module: msg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot (1 kHz/digit at 50 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 12500000, clocks per ERR blink half-period.
REQ-003 SHALL have parameter BUZZ_CYCLES, default 25000000, buzzer on-time in clocks (0.5 s).
REQ-004 SHALL have port clk_50MHz  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port msg_valid  input  1  single-cycle message load strobe.
REQ-007 SHALL have port msg_code  input  3  0=blank, 1=ON, 2=OFF, 3=ERR, 4=OPEN, 5-7 reserved.
REQ-008 SHALL have port buzz_req  input  1  level request; rising edge triggers buzzer.
REQ-009 SHALL have port seg  output  8  active-low segments, bit7=dp, bits6..0=g..a.
REQ-010 SHALL have port digit  output  4  active-low digit enables, digit[3] leftmost.
REQ-011 SHALL have port buzzer  output  1  active-high buzzer drive.

Function
REQ-012 Message register SHALL load msg_code on a clock edge where msg_valid=1 and msg_code<=4; reserved codes SHALL be ignored, register unchanged.
REQ-013 Glyphs, positions d3..d0: blank=all blank; ON=blank,blank,O,n; OFF=blank,O,F,F; ERR=blank,E,r,r; OPEN=O,P,E,n.
REQ-014 seg encodings SHALL be blank=0xFF, O=0xC0, n=0xAB, F=0x8E, E=0x86, r=0xAF, P=0x8C; dp always off (bit7=1).
REQ-015 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the 2-bit scan index SHALL advance 0->1->2->3->0.
REQ-016 digit SHALL be registered: digit[idx]=0, all other bits 1; exactly one bit low at all times after reset.
REQ-017 seg SHALL be registered from message register and scan index, updating on the same edge as digit so glyph and enable never mismatch.
REQ-018 Load latency: strobe sampled at edge N, message register valid after N, seg shows new glyph for current digit after edge N+1.
REQ-019 Blink counter SHALL count 0..BLINK_DIV-1, toggling blink phase at terminal count; phase=visible after reset.
REQ-020 While message=ERR and phase=hidden, seg SHALL be 0xFF; digit scanning SHALL continue unchanged.
REQ-021 Any accepted load (REQ-012) SHALL clear blink counter to 0 and set phase=visible on the same edge.
REQ-022 buzz_req SHALL be registered once and edge-detected; rising edge (prev 0, now 1) SHALL start the buzzer timer.
REQ-023 An accepted load of code 3 (ERR) SHALL also start the buzzer timer.
REQ-024 Timer start SHALL set buzzer=1 on the next edge and hold it exactly BUZZ_CYCLES clocks, then buzzer=0.
REQ-025 Retrigger while buzzer active SHALL restart the full BUZZ_CYCLES count (no accumulation, no gap).
REQ-026 A level-held buzz_req SHALL NOT retrigger; simultaneous ERR load and buzz_req edge SHALL count as one start.
REQ-027 All counters SHALL be sized by $clog2 of their parameter and SHALL NOT overflow for any parameter >=2.

Reset
REQ-028 With reset=1 at an edge: seg=0xFF, digit=4'b1110, buzzer=0, message=blank, scan index=0, all counters=0, blink phase=visible, buzz_req history=0.
REQ-029 reset SHALL take priority over msg_valid, buzz_req and every counter event on the same edge.
REQ-030 Reset mid-buzz SHALL drop buzzer to 0 on that edge; a buzz_req held high across deassertion SHALL trigger once (history cleared).

Verification (REFRESH_DIV=4, BLINK_DIV=16, BUZZ_CYCLES=8)
REQ-031 Reset, no input -> digit cycles 1110,1101,1011,0111 every 4 clocks; seg=0xFF throughout; buzzer=0.
REQ-032 Load code 4 (OPEN) -> over one scan seg=0xAB(d0), 0x86(d1), 0x8C(d2), 0xC0(d3), each aligned with its digit enable.
REQ-033 Load code 3 (ERR) -> buzzer high 8 clocks starting edge after load; seg alternates glyphs / 0xFF every 16 clocks; d3 always 0xFF.
REQ-034 buzz_req pulse, second pulse 5 clocks later -> buzzer continuously high 13 clocks total; buzz_req held 30 clocks -> buzzer high 8 clocks only.
REQ-035 msg_valid with code 6 while showing ON -> display remains ON (d1=0xC0, d0=0xAB), no buzzer, blink counter undisturbed.
REQ-036 reset asserted 3 clocks into buzzer and during msg_valid=1 -> next edge buzzer=0, seg=0xFF, digit=1110, message blank.

Source files
------------

// File: rtl/msg_scan_driver.sv
// Four-digit multiplexed seven-segment message driver with ERR blink and a
// retriggerable one-shot buzzer.
module msg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int BUZZ_CYCLES = 25000000
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       msg_valid,
  input  logic [2:0] msg_code,
  input  logic       buzz_req,
  output logic [7:0] seg,
  output logic [3:0] digit,
  output logic       buzzer
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int ZW = $clog2(BUZZ_CYCLES);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [ZW-1:0] BUZZ_LAST  = ZW'(BUZZ_CYCLES - 1);

  localparam logic [2:0] MSG_BLANK = 3'd0;
  localparam logic [2:0] MSG_ERR   = 3'd3;
  localparam logic [2:0] MSG_MAX   = 3'd4;

  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_O     = 8'hC0;
  localparam logic [7:0] G_N     = 8'hAB;
  localparam logic [7:0] G_F     = 8'h8E;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_R     = 8'hAF;
  localparam logic [7:0] G_P     = 8'h8C;

  logic [RW-1:0] refresh_cnt_reg, refresh_cnt_next;
  logic [1:0]    scan_idx_reg, scan_idx_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_hidden_reg, blink_hidden_next;
  logic [2:0]    msg_reg, msg_next;
  logic          buzz_hist_reg;
  logic [ZW-1:0] buzz_cnt_reg, buzz_cnt_next;
  logic          buzzer_reg, buzzer_next;
  logic [7:0]    seg_reg, seg_next;
  logic [3:0]    digit_reg, digit_next;
  logic          load_ok;
  logic          buzz_start;

  // Glyph lookup keyed by {message, digit position}; anything unlisted is blank.
  function automatic logic [7:0] glyph(input logic [2:0] code, input logic [1:0] idx);
    logic [7:0] g;
    g = G_BLANK;
    case ({code, idx})
      5'b001_01: g = G_O;
      5'b001_00: g = G_N;
      5'b010_10: g = G_O;
      5'b010_01: g = G_F;
      5'b010_00: g = G_F;
      5'b011_10: g = G_E;
      5'b011_01: g = G_R;
      5'b011_00: g = G_R;
      5'b100_11: g = G_O;
      5'b100_10: g = G_P;
      5'b100_01: g = G_E;
      5'b100_00: g = G_N;
      default:   g = G_BLANK;
    endcase
    return g;
  endfunction

  // Enables are derived from the next scan index so they land on the same edge as seg.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_next[gi] = (scan_idx_next != 2'(gi));
  end

  always_comb begin
    load_ok           = msg_valid && (msg_code <= MSG_MAX);
    refresh_cnt_next  = refresh_cnt_reg + 1'b1;
    scan_idx_next     = scan_idx_reg;
    blink_cnt_next    = blink_cnt_reg + 1'b1;
    blink_hidden_next = blink_hidden_reg;
    msg_next          = msg_reg;
    buzz_cnt_next     = buzz_cnt_reg;
    buzzer_next       = buzzer_reg;

    if (refresh_cnt_reg == REF_LAST) begin
      refresh_cnt_next = '0;
      scan_idx_next    = scan_idx_reg + 2'd1;
    end

    if (load_ok) begin
      msg_next          = msg_code;
      blink_cnt_next    = '0;
      blink_hidden_next = 1'b0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_next    = '0;
      blink_hidden_next = ~blink_hidden_reg;
    end

    buzz_start = (buzz_req && !buzz_hist_reg) || (load_ok && msg_code == MSG_ERR);
    if (buzz_start) begin
      buzzer_next   = 1'b1;
      buzz_cnt_next = BUZZ_LAST;
    end else if (buzzer_reg) begin
      if (buzz_cnt_reg == '0) buzzer_next = 1'b0;
      else                    buzz_cnt_next = buzz_cnt_reg - 1'b1;
    end

    if (msg_reg == MSG_ERR && blink_hidden_reg) seg_next = G_BLANK;
    else                                        seg_next = glyph(msg_reg, scan_idx_next);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      refresh_cnt_reg  <= '0;
      scan_idx_reg     <= 2'd0;
      blink_cnt_reg    <= '0;
      blink_hidden_reg <= 1'b0;
      msg_reg          <= MSG_BLANK;
      buzz_hist_reg    <= 1'b0;
      buzz_cnt_reg     <= '0;
      buzzer_reg       <= 1'b0;
      seg_reg          <= G_BLANK;
      digit_reg        <= 4'b1110;
    end else begin
      refresh_cnt_reg  <= refresh_cnt_next;
      scan_idx_reg     <= scan_idx_next;
      blink_cnt_reg    <= blink_cnt_next;
      blink_hidden_reg <= blink_hidden_next;
      msg_reg          <= msg_next;
      buzz_hist_reg    <= buzz_req;
      buzz_cnt_reg     <= buzz_cnt_next;
      buzzer_reg       <= buzzer_next;
      seg_reg          <= seg_next;
      digit_reg        <= digit_next;
    end
  end

  assign seg    = seg_reg;
  assign digit  = digit_reg;
  assign buzzer = buzzer_reg;
endmodule

// File: tb/tb_msg_scan_driver.sv
// Directed bench for msg_scan_driver with short divider parameters
// (refresh 4, blink 16, buzzer 8).
module tb_msg_scan_driver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       msg_valid = 1'b0;
  logic [2:0] msg_code = 3'd0;
  logic       buzz_req = 1'b0;
  logic [7:0] seg;
  logic [3:0] digit;
  logic       buzzer;
  int checks = 0;
  int errors = 0;

  msg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16), .BUZZ_CYCLES(8)) dut (
    .clk_50MHz(clk),
    .reset    (reset),
    .msg_valid(msg_valid),
    .msg_code (msg_code),
    .buzz_req (buzz_req),
    .seg      (seg),
    .digit    (digit),
    .buzzer   (buzzer)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_open(input logic [3:0] d);
    case (d)
      4'b1110: return 8'hAB;
      4'b1101: return 8'h86;
      4'b1011: return 8'h8C;
      4'b0111: return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_err(input logic [3:0] d);
    case (d)
      4'b1110: return 8'hAF;
      4'b1101: return 8'hAF;
      4'b1011: return 8'h86;
      4'b0111: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_on(input logic [3:0] d);
    case (d)
      4'b1110: return 8'hAB;
      4'b1101: return 8'hC0;
      4'b1011: return 8'hFF;
      4'b0111: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", seg); end
    checks++;
    if (digit !== 4'b1110) begin errors++; $display("FAIL reset_digit: got %b expected 1110", digit); end
    checks++;
    if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b expected 0", buzzer); end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] dig_tab [4];
    dig_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 1; i <= 16; i++) begin
      cyc();
      checks++;
      if (digit !== dig_tab[(i / 4) % 4]) begin
        errors++; $display("FAIL scan_digit[%0d]: got %b expected %b", i, digit, dig_tab[(i / 4) % 4]);
      end
      checks++;
      if (seg !== 8'hFF) begin errors++; $display("FAIL scan_seg[%0d]: got %h expected ff", i, seg); end
      checks++;
      if (buzzer !== 1'b0) begin errors++; $display("FAIL scan_buzzer[%0d]: got %b expected 0", i, buzzer); end
    end
  endtask

  task automatic test_open();
    logic [3:0] seen;
    seen = 4'b0000;
    msg_valid = 1'b1; msg_code = 3'd4;
    cyc();
    msg_valid = 1'b0; msg_code = 3'd0;
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL open_latency: got %h expected ff", seg); end
    for (int k = 1; k <= 16; k++) begin
      cyc();
      seen = seen | ~digit;
      checks++;
      if (seg !== exp_open(digit)) begin
        errors++; $display("FAIL open_seg[%0d]: digit %b got %h expected %h", k, digit, seg, exp_open(digit));
      end
    end
    checks++;
    if (seen !== 4'hF) begin errors++; $display("FAIL open_all_digits: got %b expected 1111", seen); end
  endtask

  task automatic test_err();
    logic [7:0] e;
    msg_valid = 1'b1; msg_code = 3'd3;
    cyc();
    msg_valid = 1'b0; msg_code = 3'd0;
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL err_buzz_start: got %b expected 1", buzzer); end
    for (int k = 1; k <= 48; k++) begin
      cyc();
      e = ((k <= 16) || (k >= 33)) ? exp_err(digit) : 8'hFF;
      checks++;
      if (seg !== e) begin errors++; $display("FAIL err_seg[%0d]: digit %b got %h expected %h", k, digit, seg, e); end
      checks++;
      if (buzzer !== (k <= 7)) begin
        errors++; $display("FAIL err_buzzer[%0d]: got %b expected %b", k, buzzer, (k <= 7));
      end
    end
  endtask

  task automatic test_retrigger();
    checks++;
    if (buzzer !== 1'b0) begin errors++; $display("FAIL retrig_idle: got %b expected 0", buzzer); end
    buzz_req = 1'b1;
    cyc();
    buzz_req = 1'b0;
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL retrig_start: got %b expected 1", buzzer); end
    for (int k = 1; k <= 14; k++) begin
      buzz_req = (k == 5);
      cyc();
      buzz_req = 1'b0;
      checks++;
      if (buzzer !== (k <= 12)) begin
        errors++; $display("FAIL retrig_buzzer[%0d]: got %b expected %b", k, buzzer, (k <= 12));
      end
    end
    buzz_req = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      checks++;
      if (buzzer !== (k <= 7)) begin
        errors++; $display("FAIL held_buzzer[%0d]: got %b expected %b", k, buzzer, (k <= 7));
      end
    end
    buzz_req = 1'b0;
    cyc();
  endtask

  task automatic test_reserved();
    logic [7:0] e;
    msg_valid = 1'b1; msg_code = 3'd1;
    cyc();
    msg_valid = 1'b1; msg_code = 3'd6;
    cyc();
    msg_valid = 1'b1; msg_code = 3'd7;
    cyc();
    msg_valid = 1'b0; msg_code = 3'd0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++;
      if (seg !== exp_on(digit)) begin
        errors++; $display("FAIL rsv_on_seg[%0d]: digit %b got %h expected %h", k, digit, seg, exp_on(digit));
      end
      checks++;
      if (buzzer !== 1'b0) begin errors++; $display("FAIL rsv_on_buzzer[%0d]: got %b expected 0", k, buzzer); end
    end
    // A reserved strobe mid-blink must not restart the blink period.
    msg_valid = 1'b1; msg_code = 3'd3;
    cyc();
    for (int k = 1; k <= 20; k++) begin
      msg_valid = (k == 5);
      msg_code  = (k == 5) ? 3'd6 : 3'd0;
      cyc();
      e = (k <= 16) ? exp_err(digit) : 8'hFF;
      checks++;
      if (seg !== e) begin errors++; $display("FAIL rsv_blink_seg[%0d]: digit %b got %h expected %h", k, digit, seg, e); end
    end
    msg_valid = 1'b0; msg_code = 3'd0;
  endtask

  task automatic test_reset_mid();
    buzz_req = 1'b1;
    cyc();
    buzz_req = 1'b0;
    cyc();
    cyc();
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL mid_pre_buzzer: got %b expected 1", buzzer); end
    reset = 1'b1; msg_valid = 1'b1; msg_code = 3'd4; buzz_req = 1'b1;
    cyc();
    checks++;
    if (buzzer !== 1'b0) begin errors++; $display("FAIL mid_buzzer: got %b expected 0", buzzer); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL mid_seg: got %h expected ff", seg); end
    checks++;
    if (digit !== 4'b1110) begin errors++; $display("FAIL mid_digit: got %b expected 1110", digit); end
    reset = 1'b0; msg_valid = 1'b0; msg_code = 3'd0;
    cyc();
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL mid_held_trigger: got %b expected 1", buzzer); end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      checks++;
      if (buzzer !== (k <= 7)) begin
        errors++; $display("FAIL mid_buzzer_run[%0d]: got %b expected %b", k, buzzer, (k <= 7));
      end
      checks++;
      if (seg !== 8'hFF) begin errors++; $display("FAIL mid_blank_seg[%0d]: got %h expected ff", k, seg); end
    end
    buzz_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_open();
    test_err();
    test_retrigger();
    test_reserved();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
